// File: rtl/pipeline_if_id.sv
// pipeline_if_id: IF/ID boundary register with hazard control.
//
// Latches the fetched instruction and its PC+4 for the decode stage. It
// raises a one-cycle load-use stall and swaps in a bubble when a branch or
// jump flushes the pipe. After an end-of-program word reaches decode, a
// small RUN/DRAIN/HALTED machine lets the pipe empty and then reports halted.
//
// Build option: define IF_ID_STALL_COUNT_EN to build the saturating 16-bit
// load-use stall counter. Without it, stallCount is tied to zero.

module pipeline_if_id #(
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instructionIn,
    input  logic [31:0] pcPlus4In,
    input  logic        branchTaken,
    input  logic        jumpTaken,
    input  logic        idExMemRead,
    input  logic [4:0]  idExRd,
    output logic [31:0] instructionOut,
    output logic [31:0] pcPlus4IdOut,
    output logic        validOut,
    output logic        stall,
    output logic        halted,
    output logic [15:0] stallCount
);

    // End-of-program marker lives in the low 12 bits of the latched word.
    localparam logic [11:0] EOP_MARK  = 12'h300;
    // Drain counter preload; DRAIN_CYCLES is limited to 1..15 so 4 bits suffice.
    localparam logic [3:0]  DRAIN_TOP = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Architectural state of the boundary register and its controller.
    state_t      r_state;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [3:0]  r_drain_cnt;

    // Next-state values computed combinationally.
    state_t      w_state_next;
    logic [31:0] w_instr_next;
    logic [31:0] w_pc_next;
    logic        w_valid_next;
    logic [3:0]  w_drain_cnt_next;

    // Decoded fields of the instruction currently held for decode.
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;

    // Hazard and control terms.
    logic        w_in_run;
    logic        w_flush;
    logic        w_hazard;
    logic        w_stall;
    logic        w_eop;

    assign w_opcode = r_instr[31:26];
    assign w_rs1    = r_instr[25:21];
    assign w_rs2    = r_instr[20:16];

    assign w_in_run = (r_state == ST_RUN);

    // branchTaken is already gated by ~stall upstream; jumpTaken is not.
    // That is why a flush can coincide with a stall, and the flush wins.
    assign w_flush = branchTaken | jumpTaken;

    // Load-use hazard: the load in EX writes a register that the instruction
    // in decode reads. rs2 is a real source only for R-type (opcode 0).
    // Register 0 is never a real dependency.
    assign w_hazard = r_valid
                    & idExMemRead
                    & (idExRd != 5'd0)
                    & ((idExRd == w_rs1)
                       | ((w_opcode == 6'd0) & (idExRd == w_rs2)));

    // Stall is only meaningful while the pipe is running.
    assign w_stall = w_in_run & w_hazard;

    // A bubble can never signal end-of-program, even if NOP_WORD matches.
    assign w_eop = r_valid & (r_instr[11:0] == EOP_MARK);

    // Next-state logic for the register contents, state and drain counter.
    always_comb begin
        w_state_next     = r_state;
        w_instr_next     = r_instr;
        w_pc_next        = r_pc;
        w_valid_next     = r_valid;
        w_drain_cnt_next = r_drain_cnt;

        case (r_state)
            ST_RUN: begin
                if (w_flush) begin
                    // Squash the wrong-path word but keep its PC+4 flowing.
                    // A flush also cancels a pending end-of-program.
                    w_instr_next = NOP_WORD;
                    w_valid_next = 1'b0;
                    w_pc_next    = pcPlus4In;
                end else if (w_eop) begin
                    // Stop accepting fetch output and start draining.
                    w_instr_next     = NOP_WORD;
                    w_valid_next     = 1'b0;
                    w_state_next     = ST_DRAIN;
                    w_drain_cnt_next = DRAIN_TOP;
                end else if (w_stall) begin
                    // Hold everything for one cycle while the load completes.
                    w_instr_next = r_instr;
                    w_pc_next    = r_pc;
                    w_valid_next = r_valid;
                end else begin
                    w_instr_next = instructionIn;
                    w_pc_next    = pcPlus4In;
                    w_valid_next = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Inputs are ignored; keep presenting a bubble downstream.
                w_instr_next = NOP_WORD;
                w_valid_next = 1'b0;
                if (r_drain_cnt == 4'd0) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - 4'd1;
                end
            end

            ST_HALTED: begin
                // Terminal until reset.
                w_instr_next = NOP_WORD;
                w_valid_next = 1'b0;
            end

            default: begin
                w_state_next     = ST_RUN;
                w_instr_next     = NOP_WORD;
                w_valid_next     = 1'b0;
                w_drain_cnt_next = 4'd0;
            end
        endcase
    end

    // State machine and drain counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // IF/ID pipeline register: instruction, PC+4 and valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= NOP_WORD;
            r_pc    <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else begin
            r_instr <= w_instr_next;
            r_pc    <= w_pc_next;
            r_valid <= w_valid_next;
        end
    end

`ifdef IF_ID_STALL_COUNT_EN
    // Saturating count of cycles spent stalled on load-use hazards.
    logic [15:0] r_stall_cnt;

    // Count every stalled edge and stop at all-ones rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stallCount = r_stall_cnt;
`else
    assign stallCount = 16'h0000;
`endif

    assign instructionOut = r_instr;
    assign pcPlus4IdOut   = r_pc;
    assign validOut       = r_valid;
    assign stall          = w_stall;
    assign halted         = (r_state == ST_HALTED);

endmodule

// File: doc/pipeline_if_id.md
# pipeline_if_id

IF/ID boundary register with hazard control, placed between `pipeline_fetch` and the decode stage. It latches the fetched instruction and its PC+4, and raises `stall` on a load-use hazard. It replaces the latched instruction with a bubble when a taken branch or jump flushes the pipe. A small state machine drains the pipeline after an end-of-program instruction and then reports `halted`.

## Interface
- `NOP_WORD`, default 32'h0000_0000, instruction word inserted as a bubble.
- `DRAIN_CYCLES`, default 3, cycles spent in DRAIN before HALTED (range 1–15).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `instructionIn`  in  32  word from instruction memory at fetch's `currentAddress`.
- `pcPlus4In`  in  32  fetch's `pcPlus4Out`.
- `branchTaken`  in  1  fetch's `branchOut`.
- `jumpTaken`  in  1  jump or jumpReg resolved in ID this cycle.
- `idExMemRead`  in  1  the instruction now in EX is a load.
- `idExRd`  in  5  destination register of the instruction now in EX.
- `instructionOut`  out  32  latched instruction to decode (`instruction` input of fetch).
- `pcPlus4IdOut`  out  32  latched PC+4 (fetch `pcPlus4Id`).
- `validOut`  out  1  `instructionOut` is a real instruction, not a bubble.
- `stall`  out  1  load-use hold request to fetch and to this register.
- `halted`  out  1  pipeline drained after end-of-program.
- `stallCount`  out  16  load-use stall cycle counter (see Configuration).

## Operation
- Field decode of `instructionOut`: opcode [31:26], rs1 [25:21], rs2 [20:16].
- An instruction is end-of-program when `instructionOut[11:0] == 12'h300` and `validOut` is 1.
- A load-use hazard exists when all of the following hold:
  - `validOut` is 1, `idExMemRead` is 1 and `idExRd` is not 0.
  - Either `idExRd == rs1`, or opcode is 0 (R-type) and `idExRd == rs2`.
- `stall` equals the hazard signal, combinational from the register contents and inputs, while in RUN. It is 0 in every other state.
- Per-edge register update in RUN, highest priority first:
  1. `branchTaken | jumpTaken`: load `NOP_WORD`, `validOut` = 0, and latch `pcPlus4In`.
  2. `stall`: hold all contents.
  3. Otherwise: load `instructionIn` and `pcPlus4In`, `validOut` = 1.
- States: RUN, DRAIN, HALTED.
  - RUN → DRAIN on the edge where `instructionOut` is end-of-program and no flush is active. A flush in that cycle cancels the end-of-program and the state stays RUN.
  - On RUN → DRAIN the register loads a bubble, and the drain counter loads `DRAIN_CYCLES-1`.
  - DRAIN: register holds a bubble and all inputs are ignored. The counter decrements each cycle, and the state moves to HALTED on the edge where the counter reads 0.
  - HALTED: terminal, `halted` = 1. Only `reset` leaves this state.
- `reset` in any state, including mid-DRAIN, returns to RUN and sets:
  - `instructionOut` = `NOP_WORD`, `pcPlus4IdOut` = 0, `validOut` = 0.
  - `stall` = 0, `halted` = 0, `stallCount` = 0, drain counter = 0.

## Timing
- Latency: `instructionIn` appears on `instructionOut` one edge later when neither stalled nor flushed.
- A stall lasts exactly one cycle per hazard. After the hold the EX instruction has advanced, so the hazard clears unless a new one is presented.
- `branchTaken` already carries `~stall` gating, so flush and stall together arise only through `jumpTaken`. Flush wins.
- From the end-of-program instruction appearing at `instructionOut` to `halted` = 1 takes `DRAIN_CYCLES` + 1 edges.
- No combinational path from `instructionIn` to any output.

## Configuration
- `IF_ID_STALL_COUNT_EN`:
  - Defined: `stallCount` increments on every edge where `stall` is 1 and saturates at 16'hFFFF.
  - Undefined: the counter is not built and `stallCount` is tied to 0. The port exists in both builds.

## Test plan
- Reset mid-stream: assert `reset` during DRAIN → all outputs return to reset values asynchronously; state is RUN after release.
- Straight-line: feed `instructionIn`=32'h2001_0005 with `pcPlus4In`=32'h10 → next edge `instructionOut`=32'h2001_0005, `pcPlus4IdOut`=32'h10, `validOut`=1.
- Load-use: with `instructionOut` holding R-type rs2=7, drive `idExMemRead`=1 and `idExRd`=7 → `stall`=1 for one cycle, contents held; with `idExRd`=0 → `stall`=0.
- Flush: assert `branchTaken` while a new word is presented → `instructionOut`=`NOP_WORD` and `validOut`=0 next edge; `jumpTaken` together with a stall also flushes.
- End of program: latch a word with [11:0]=12'h300 and leave `DRAIN_CYCLES`=3 → `halted` rises 4 edges later; later inputs are ignored. Repeat with `branchTaken`=1 in the same cycle → no halt.
- Counter: produce 3 separate hazards → `stallCount`=3 with `IF_ID_STALL_COUNT_EN` defined, 0 without it; force 65536 stall cycles → saturates at 16'hFFFF.
